// File: rtl/port_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the blank-digit code and a power-of-ten
// constant function used to size the overflow threshold.
package port_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // sevenseg renders this code as an unlit digit
    localparam logic [3:0] BLANK_CODE = 4'hF;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
// Ports: din  - current accumulator digit
//        dout - digit corrected ahead of the left shift
module bcd_digit_adj
    import port_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Only values 0..9 reach this block, so the 4-bit sum never wraps.
    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/port_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per cycle).
// Latency: WIDTH+1 edges from accepted start to done; one conversion per WIDTH+2 cycles.
// Backpressure: start is only honoured in IDLE; starts seen while busy are dropped, not queued.
// Ports: clock/reset  - clock, synchronous active-high reset
//        start/din    - conversion request and the binary value to capture
//        busy/done    - conversion in flight / one-cycle result strobe
//        bcd/overflow - held result (units digit in [3:0]) and value >= 10^DIGITS flag
module port_bcd_converter
    import port_bcd_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DIGITS   = 2,
    parameter int BLANK_LZ = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    din,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 4 * DIGITS;

    // Largest value representable in DIGITS decimal digits. If it does not fit
    // in WIDTH bits then no input can exceed it and overflow is constant 0.
    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam bit              CAN_OVF = (WIDTH >= 64) || (MAX_VAL < (64'd1 << WIDTH));
    localparam logic [WIDTH-1:0] MAX_DIN = WIDTH'(MAX_VAL);

    state_t            state;
    logic [WIDTH-1:0]  sreg;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_adj;
    logic [AW-1:0]     acc_out;
    logic [CW-1:0]     cnt;
    logic              ovf_next;
    logic              lead;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc[4*g +: 4]),
            .dout (acc_adj[4*g +: 4])
        );
    end

    // Leading-zero blanking: walk down from the top digit and blank zeros
    // until the first nonzero digit. The units digit is never considered.
    always_comb begin
        acc_out = acc;
        lead    = 1'b1;
        if (BLANK_LZ != 0) begin
            for (int d = DIGITS - 1; d >= 1; d--) begin
                if (lead && (acc[4*d +: 4] == 4'd0)) begin
                    acc_out[4*d +: 4] = BLANK_CODE;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            sreg     <= '0;
            ovf_next <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg     <= din;
                        acc      <= '0;
                        cnt      <= CW'(WIDTH);
                        ovf_next <= CAN_OVF && (din > MAX_DIN);
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Truncating cast drops the carry out of the top digit,
                    // which is what makes the result din mod 10^DIGITS.
                    acc  <= AW'({acc_adj, sreg[WIDTH-1]});
                    sreg <= sreg << 1;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd      <= acc_out;
                    overflow <= ovf_next;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port_bcd_converter.sv
// Directed bench for port_bcd_converter: two instances (plain and leading-zero
// blanking) share all inputs; outputs are sampled on the falling edge.
module tb_port_bcd_converter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] din;
    logic        busy, done, overflow;
    logic [7:0]  bcd;
    logic        busy_b, done_b, overflow_b;
    logic [7:0]  bcd_b;

    int n_vec = 0;
    int n_bad = 0;

    port_bcd_converter #(.WIDTH(32), .DIGITS(2), .BLANK_LZ(0)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    port_bcd_converter #(.WIDTH(32), .DIGITS(2), .BLANK_LZ(1)) u_dut_blk (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .din      (din),
        .busy     (busy_b),
        .done     (done_b),
        .bcd      (bcd_b),
        .overflow (overflow_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] din;
        logic [7:0]  bcd;
        logic        ovf;
        logic [7:0]  bcd_blk;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd2(input int v);
        logic [3:0] tens, units;
        tens  = 4'((v / 10) % 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

    // Pulse start for one edge, then wait (bounded) for done and check the
    // latency, the held result while busy, and the one-cycle done pulse.
    task automatic run_conv(input string name, input logic [31:0] v,
                            input logic [7:0] exp_bcd, input logic exp_ovf,
                            input logic [7:0] exp_blk);
        int         lat;
        logic       early;
        logic [7:0] prev;
        @(negedge clock);
        din   = v;
        start = 1'b1;
        prev  = bcd;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        din   = 32'hDEAD_BEEF;
        chk({name, " busy_after_accept"}, 32'(busy), 32'd1);
        lat   = 0;
        early = 1'b0;
        while (!done && lat < 100) begin
            if (bcd !== prev) early = 1'b1;
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        chk({name, " latency"},      32'(lat),        32'd33);
        chk({name, " held_stable"},  32'(early),      32'd0);
        chk({name, " busy_in_done"}, 32'(busy),       32'd0);
        chk({name, " bcd"},          32'(bcd),        32'(exp_bcd));
        chk({name, " overflow"},     32'(overflow),   32'(exp_ovf));
        chk({name, " bcd_blank"},    32'(bcd_b),      32'(exp_blk));
        chk({name, " done_blank"},   32'(done_b),     32'd1);
        @(negedge clock);
        chk({name, " done_one_cycle"}, 32'(done),     32'd0);
    endtask

    initial begin
        int         dones;
        int         spurious;
        int         glitch;
        logic [7:0] held;
        logic [7:0] last_bcd;

        vecs[0]  = '{32'd47,         8'h47, 1'b0, 8'h47};
        vecs[1]  = '{32'd100,        8'h00, 1'b1, 8'hF0};
        vecs[2]  = '{32'hFFFF_FFFF,  8'h95, 1'b1, 8'h95};
        vecs[3]  = '{32'd5,          8'h05, 1'b0, 8'hF5};
        vecs[4]  = '{32'd0,          8'h00, 1'b0, 8'hF0};
        vecs[5]  = '{32'd90,         8'h90, 1'b0, 8'h90};
        vecs[6]  = '{32'd99,         8'h99, 1'b0, 8'h99};
        vecs[7]  = '{32'd12345,      8'h45, 1'b1, 8'h45};
        vecs[8]  = '{32'd7,          8'h07, 1'b0, 8'hF7};
        vecs[9]  = '{32'd10,         8'h10, 1'b0, 8'h10};
        vecs[10] = '{32'd101,        8'h01, 1'b1, 8'hF1};

        reset = 1'b1;
        start = 1'b0;
        din   = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset busy",     32'(busy),     32'd0);
        chk("reset done",     32'(done),     32'd0);
        chk("reset bcd",      32'(bcd),      32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset bcd_blk",  32'(bcd_b),    32'd0);

        for (int i = 0; i < 11; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].din, vecs[i].bcd,
                     vecs[i].ovf, vecs[i].bcd_blk);
        end

        // Start mid-conversion is dropped: only one done, carrying the first value.
        @(negedge clock);
        din   = 32'd12;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        din   = 32'd34;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        dones = 0;
        held  = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) begin
                dones++;
                held = bcd;
            end
        end
        chk("midstart done_count", 32'(dones), 32'd1);
        chk("midstart bcd",        32'(held),  32'h12);
        chk("midstart idle",       32'(busy),  32'd0);

        // Reset at edge 15 of a conversion aborts it with no done pulse.
        @(negedge clock);
        din   = 32'd77;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort busy",     32'(busy),     32'd0);
        chk("abort bcd",      32'(bcd),      32'd0);
        chk("abort done",     32'(done),     32'd0);
        chk("abort overflow", 32'(overflow), 32'd0);
        chk("abort bcd_blk",  32'(bcd_b),    32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done || done_b) dones++;
        end
        chk("abort no_done", 32'(dones), 32'd0);
        run_conv("after_abort", 32'd77, 8'h77, 1'b0, 8'h77);

        // Free-running: start held high, din = cycle index mod 100 at each edge.
        // Accepts land on edges 0, 34, 68, 102; results appear after edges 33, 67, 101, 135.
        repeat (2) @(negedge clock);
        spurious = 0;
        glitch   = 0;
        last_bcd = bcd;
        start    = 1'b1;
        for (int c = 0; c < 136; c++) begin
            din = 32'(c % 100);
            @(posedge clock);
            @(negedge clock);
            if ((c % 34) == 33) begin
                chk($sformatf("freerun done@%0d", c), 32'(done), 32'd1);
                chk($sformatf("freerun bcd@%0d", c),  32'(bcd),
                    32'(to_bcd2((c - 33) % 100)));
                chk($sformatf("freerun ovf@%0d", c),  32'(overflow), 32'd0);
                last_bcd = bcd;
            end else begin
                if (done) spurious++;
                if (bcd !== last_bcd) glitch++;
            end
        end
        start = 1'b0;
        chk("freerun spurious_done", 32'(spurious), 32'd0);
        chk("freerun bcd_glitch",    32'(glitch),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
